// File: rtl/shiftreg_buf_pkg.sv
// Shared types and defaults for the code-block collection buffer.
package shiftreg_buf_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int MAX_K      = 6144;
  localparam int DEPTH_DEF  = 769;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shiftreg_buf_align.sv
// Registered barrel realigner: moves the MSB-justified block down so the
// earliest word lands at bit 0. Used only with SHIFTREG_BUF_LSB_ALIGN_EN.
module shiftreg_buf_align
  import shiftreg_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = cnt_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    aclr,
  input  logic [DEPTH*DATA_W-1:0] mem,
  input  logic [CNT_W-1:0]        fill_cnt,
  input  logic                    blk_valid,
  output logic [DEPTH*DATA_W-1:0] q_out,
  output logic                    q_valid
);

  localparam int QW   = DEPTH * DATA_W;
  localparam int SH_W = $clog2(QW + 1);

  logic [SH_W-1:0] shamt_s;

  assign shamt_s = SH_W'((DEPTH - int'(fill_cnt)) * DATA_W);

  // Aligned image and its valid flag, one cycle behind the buffer.
  always_ff @(posedge clk) begin
    if (aclr) begin
      q_out   <= {QW{1'b0}};
      q_valid <= 1'b0;
    end else begin
      q_out   <= mem >> shamt_s;
      q_valid <= blk_valid;
    end
  end

endmodule

// File: rtl/shiftreg_buf_blk.sv
// Code-block collection buffer: shifts in words, holds a block until acked.
// Optional LSB alignment of q_out under SHIFTREG_BUF_LSB_ALIGN_EN.
module shiftreg_buf_blk
  import shiftreg_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = cnt_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    aclr,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CNT_W-1:0]        blk_len,
  input  logic                    flush,
  output logic [DEPTH*DATA_W-1:0] q_out,
  output logic                    q_valid,
  input  logic                    q_ack,
  output logic [CNT_W-1:0]        fill_cnt
);

  localparam int QW = DEPTH * DATA_W;

  state_t           state_r, state_s;
  logic [QW-1:0]    mem_r, mem_s;
  logic [CNT_W-1:0] fill_r, fill_s;
  logic [CNT_W-1:0] len_r, len_s, len_sel_s;
  logic             accept_s;

  assign in_ready  = (state_r == FILL) || q_ack;
  assign accept_s  = in_valid && in_ready;
  assign len_sel_s = ((blk_len == {CNT_W{1'b0}}) || (blk_len > CNT_W'(DEPTH))) ?
                     CNT_W'(DEPTH) : blk_len;
  assign fill_cnt  = fill_r;

  // Next-state, shift and block-length logic.
  always_comb begin
    state_s = state_r;
    mem_s   = mem_r;
    fill_s  = fill_r;
    len_s   = len_r;
    case (state_r)
      FILL: begin
        if (accept_s) begin
          mem_s  = {in_data, mem_r[QW-1:DATA_W]};
          fill_s = fill_r + CNT_W'(1'b1);
          if (fill_r == {CNT_W{1'b0}}) begin
            len_s = len_sel_s;
          end else begin
            len_s = len_r;
          end
          // Flush after a same-cycle accept always has a non-zero count.
          if ((fill_s == len_s) || flush) begin
            state_s = HOLD;
          end else begin
            state_s = FILL;
          end
        end else if (flush && (fill_r != {CNT_W{1'b0}})) begin
          state_s = HOLD;
        end else begin
          state_s = FILL;
        end
      end
      HOLD: begin
        if (q_ack && accept_s) begin
          mem_s   = {in_data, {(QW-DATA_W){1'b0}}};
          fill_s  = CNT_W'(1'b1);
          len_s   = len_sel_s;
          state_s = (len_sel_s == CNT_W'(1'b1)) ? HOLD : FILL;
        end else if (q_ack) begin
          mem_s   = {QW{1'b0}};
          fill_s  = {CNT_W{1'b0}};
          state_s = FILL;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = FILL;
      end
    endcase
  end

  // Buffer state registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (aclr) begin
      state_r <= FILL;
      mem_r   <= {QW{1'b0}};
      fill_r  <= {CNT_W{1'b0}};
      len_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      mem_r   <= mem_s;
      fill_r  <= fill_s;
      len_r   <= len_s;
    end
  end

`ifdef SHIFTREG_BUF_LSB_ALIGN_EN
  shiftreg_buf_align #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_align (
    .clk       (clk),
    .aclr      (aclr),
    .mem       (mem_r),
    .fill_cnt  (fill_r),
    .blk_valid ((state_r == HOLD) && !q_ack),
    .q_out     (q_out),
    .q_valid   (q_valid)
  );
`else
  logic q_valid_r;

  // Block-valid flag tracks the registered HOLD state.
  always_ff @(posedge clk) begin
    if (aclr) begin
      q_valid_r <= 1'b0;
    end else begin
      q_valid_r <= (state_s == HOLD);
    end
  end

  assign q_out   = mem_r;
  assign q_valid = q_valid_r;
`endif

endmodule

// File: tb/tb_shiftreg_buf_blk.sv
// Self-checking bench for shiftreg_buf_blk: directed table, corner sequences
// and randomized traffic against a queue-based block model.
module tb_shiftreg_buf_blk;
  import shiftreg_buf_pkg::*;

  localparam int DATA_W = DATA_W_DEF;
  localparam int DEPTH  = DEPTH_DEF;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int QW     = DEPTH * DATA_W;

  logic              clk = 1'b0;
  logic              aclr, in_valid, in_ready, flush, q_valid, q_ack;
  logic [DATA_W-1:0] in_data;
  logic [CNT_W-1:0]  blk_len, fill_cnt;
  logic [QW-1:0]     q_out;

  shiftreg_buf_blk #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .aclr(aclr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .blk_len(blk_len), .flush(flush), .q_out(q_out),
    .q_valid(q_valid), .q_ack(q_ack), .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: words of the current block in arrival order.
  logic [DATA_W-1:0] m_q[$];
  bit                m_hold = 1'b0;
  int                m_len  = 0;
  logic [QW-1:0]     m_align_img = '0;
  bit                m_align_vld = 1'b0;
  logic              last_rdy;
  int                n_checks = 0;
  int                n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_img(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    bit found;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      found = 1'b0;
      for (int w = 0; w < DEPTH; w++) begin
        if (!found && (act[w*DATA_W +: DATA_W] !== exp[w*DATA_W +: DATA_W])) begin
          found = 1'b1;
          $display("FAIL %s word %0d: got 0x%0h, expected 0x%0h", name, w,
                   act[w*DATA_W +: DATA_W], exp[w*DATA_W +: DATA_W]);
        end
      end
    end
  endtask

  function automatic logic [QW-1:0] img(input bit lsb);
    logic [QW-1:0] r;
    int n;
    r = '0;
    n = m_q.size();
    for (int i = 0; i < n; i++) begin
      if (lsb) r[i*DATA_W +: DATA_W] = m_q[i];
      else     r[(DEPTH-n+i)*DATA_W +: DATA_W] = m_q[i];
    end
    return r;
  endfunction

  function automatic int clamp(input int l);
    return ((l == 0) || (l > DEPTH)) ? DEPTH : l;
  endfunction

  // One clock: drive, check in_ready, advance model, check registered outputs.
  task automatic step(input bit a, input bit v, input logic [DATA_W-1:0] d,
                      input int len, input bit f, input bit ak);
    logic [QW-1:0] pre_img;
    bit pre_hold;
    aclr = a; in_valid = v; in_data = d; blk_len = CNT_W'(len); flush = f; q_ack = ak;
    #1;
    last_rdy = in_ready;
    chk("in_ready", in_ready, (!m_hold || ak));
    pre_img  = img(1'b1);
    pre_hold = m_hold;
    @(posedge clk);
    if (a) begin
      m_q.delete(); m_hold = 1'b0; m_len = 0;
    end else if (!m_hold) begin
      if (v) begin
        if (m_q.size() == 0) m_len = clamp(len);
        m_q.push_back(d);
        if (m_q.size() == m_len) m_hold = 1'b1;
      end
      if (!m_hold && f && (m_q.size() > 0)) m_hold = 1'b1;
    end else if (ak) begin
      m_q.delete(); m_hold = 1'b0;
      if (v) begin
        m_len = clamp(len);
        m_q.push_back(d);
        if (m_len == 1) m_hold = 1'b1;
      end
    end
    m_align_img = a ? '0 : pre_img;
    m_align_vld = !a && pre_hold && !ak;
    #1;
`ifdef SHIFTREG_BUF_LSB_ALIGN_EN
    cmp_img("q_out", q_out, m_align_img);
    chk("q_valid", q_valid, m_align_vld);
`else
    cmp_img("q_out", q_out, img(1'b0));
    chk("q_valid", q_valid, m_hold);
`endif
    chk("fill_cnt", fill_cnt, m_q.size());
  endtask

  typedef struct {
    logic a, v; logic [7:0] d; int len; logic f, ak;
    logic rdy, vld; int fill; logic [7:0] top;
  } vec_t;
  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 8'h01,  5, 1'b0, 1'b0, 1'b1, 1'b0, 1, 8'h01};
    tbl[1]  = '{1'b0, 1'b1, 8'h02,  5, 1'b0, 1'b0, 1'b1, 1'b0, 2, 8'h02};
    tbl[2]  = '{1'b0, 1'b1, 8'h03,  5, 1'b0, 1'b0, 1'b1, 1'b0, 3, 8'h03};
    tbl[3]  = '{1'b0, 1'b1, 8'h04,  5, 1'b0, 1'b0, 1'b1, 1'b0, 4, 8'h04};
    tbl[4]  = '{1'b0, 1'b1, 8'h05,  5, 1'b0, 1'b0, 1'b1, 1'b1, 5, 8'h05};
    tbl[5]  = '{1'b0, 1'b1, 8'h77,  5, 1'b0, 1'b0, 1'b0, 1'b1, 5, 8'h05};
    tbl[6]  = '{1'b0, 1'b1, 8'hAA,  5, 1'b0, 1'b1, 1'b1, 1'b0, 1, 8'hAA};
    tbl[7]  = '{1'b1, 1'b1, 8'h55,  5, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00};
    tbl[8]  = '{1'b0, 1'b1, 8'h10, 40, 1'b0, 1'b0, 1'b1, 1'b0, 1, 8'h10};
    tbl[9]  = '{1'b0, 1'b1, 8'h20, 40, 1'b0, 1'b0, 1'b1, 1'b0, 2, 8'h20};
    tbl[10] = '{1'b0, 1'b1, 8'h30, 40, 1'b0, 1'b0, 1'b1, 1'b0, 3, 8'h30};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 40, 1'b1, 1'b0, 1'b1, 1'b1, 3, 8'h30};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 40, 1'b0, 1'b1, 1'b1, 1'b0, 0, 8'h00};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 40, 1'b1, 1'b0, 1'b1, 1'b0, 0, 8'h00};
    tbl[14] = '{1'b0, 1'b1, 8'h44, 40, 1'b1, 1'b0, 1'b1, 1'b1, 1, 8'h44};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 40, 1'b0, 1'b1, 1'b1, 1'b0, 0, 8'h00};

    aclr = 1'b1; in_valid = 1'b0; in_data = '0; blk_len = '0; flush = 1'b0; q_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aclr = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_q_valid", q_valid, 1'b0);
    chk("rst_fill_cnt", fill_cnt, 0);
    cmp_img("rst_q_out", q_out, '0);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].a, tbl[i].v, tbl[i].d, tbl[i].len, tbl[i].f, tbl[i].ak);
      chk($sformatf("tbl%0d_ready", i), last_rdy, tbl[i].rdy);
      chk($sformatf("tbl%0d_fill", i), fill_cnt, tbl[i].fill);
`ifndef SHIFTREG_BUF_LSB_ALIGN_EN
      chk($sformatf("tbl%0d_valid", i), q_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_top", i), q_out[QW-1 -: DATA_W], tbl[i].top);
`endif
    end

    // Back-pressure: a held block ignores offered words for 10 cycles.
    step(1'b0, 1'b1, 8'h5A, 2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hA5, 2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, DATA_W'($urandom), 2, 1'b0, 1'b0);
      chk("bp_ready", last_rdy, 1'b0);
      chk("bp_fill", fill_cnt, 2);
    end
    step(1'b0, 1'b1, 8'hAA, 5, 1'b0, 1'b1);
    chk("bp_ack_fill", fill_cnt, 1);
    step(1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);

    // Length clamp: both zero and oversize lengths need DEPTH accepts.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        step(1'b0, 1'b1, DATA_W'($urandom), (k == 0) ? 0 : DEPTH + 5, 1'b0, 1'b0);
`ifndef SHIFTREG_BUF_LSB_ALIGN_EN
        if (i >= DEPTH - 2) chk("clamp_valid", q_valid, (i == DEPTH - 1));
`endif
      end
      chk("clamp_fill", fill_cnt, DEPTH);
      step(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
      chk("clamp_hold_valid", q_valid, 1'b1);
      step(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
    end

    // Reset mid-block, then a one-word block.
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, DATA_W'($urandom), 200, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h99, 200, 1'b1, 1'b1);
    chk("mid_rst_fill", fill_cnt, 0);
    cmp_img("mid_rst_q_out", q_out, '0);
    step(1'b0, 1'b1, 8'h3C, 1, 1'b0, 1'b0);
    chk("one_word_ready", last_rdy, 1'b1);
    chk("one_word_fill", fill_cnt, 1);
`ifndef SHIFTREG_BUF_LSB_ALIGN_EN
    chk("one_word_valid", q_valid, 1'b1);
    chk("one_word_top", q_out[QW-1 -: DATA_W], 8'h3C);
`else
    step(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    chk("one_word_valid", q_valid, 1'b1);
    chk("one_word_lsb", q_out[DATA_W-1:0], 8'h3C);
`endif
    step(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1);

`ifdef SHIFTREG_BUF_LSB_ALIGN_EN
    // Aligned image: earliest word at the bottom, valid two cycles after.
    step(1'b0, 1'b1, 8'h11, 3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h22, 3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h33, 3, 1'b0, 1'b0);
    chk("align_valid_early", q_valid, 1'b0);
    step(1'b0, 1'b0, 8'h00, 3, 1'b0, 1'b0);
    chk("align_valid", q_valid, 1'b1);
    chk("align_lsb", q_out[23:0], 24'h332211);
    step(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
`endif

    // Randomized traffic with resets, flushes, acks and odd lengths.
    for (int i = 0; i < 3000; i++) begin
      int r, len;
      r = int'($urandom_range(0, 49));
      len = (r == 0) ? 0 : (r == 1) ? DEPTH + int'($urandom_range(0, 200))
                                    : int'($urandom_range(1, 8));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
           DATA_W'($urandom), len, ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shiftreg_buf_blk.md
Name: shiftreg_buf_blk

Overview:
Parametrised successor of the byte-shift collection buffer in the turbo-coder/interleaver input path. Collects a programmable-length code block of DATA_W-bit words with a valid/ready handshake, then presents the whole block in parallel to the interleaver. The block is held until the consumer acknowledges it. Supports short-block flush and back-pressure, so no words are lost between blocks.

Parameters:
DATA_W, 8, word width in bits (one word shifts in per accepted transfer)
DEPTH, 769, buffer depth in words (6152 bits at DATA_W=8; covers K=6144 plus timing slack)
CNT_W, $clog2(DEPTH+1), width of the fill counter and the block-length input

Ports:
clk  in  1  system clock
aclr  in  1  synchronous active-high reset; the name is kept for the codebase, but it is NOT asynchronous
in_data  in  DATA_W  input word; LSB is the earliest bit
in_valid  in  1  in_data is valid this cycle
in_ready  out  1  buffer can accept a word this cycle
blk_len  in  CNT_W  block length in words; sampled on the first accepted word of each block
flush  in  1  force end-of-block with the current fill level
q_out  out  DEPTH*DATA_W  parallel block image
q_valid  out  1  complete block held in q_out
q_ack  in  1  consumer has taken the block
fill_cnt  out  CNT_W  words accepted in the current block

Behaviour:
- Clock and reset: one clock, clk. Reset aclr is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: mem=0, q_out=0, fill_cnt=0, q_valid=0, in_ready=1, state=FILL.
- Accept condition: a word is accepted on a rising edge when in_valid && in_ready.
- Shift: each accept does mem <= {in_data, mem[DEPTH*DATA_W-1:DATA_W]} (shift right, new word enters at the top). After N accepts, the earliest word sits at word index DEPTH-N.
- Length latch: len_q is latched on the accept with fill_cnt==0.
  - blk_len==0 or blk_len>DEPTH → len_q=DEPTH.
- States:
  - FILL: in_ready=1. An accept increments fill_cnt. When the incremented count equals len_q, go to HOLD. q_valid=1 is registered, so it is visible on the cycle after the last word's edge.
  - FILL with flush=1 and fill_cnt>0 (after any same-cycle accept is counted): go to HOLD with the current count. flush with fill_cnt==0 and no accept is ignored.
  - HOLD: in_ready=0, q_valid=1, mem frozen, fill_cnt frozen (reports block size).
  - HOLD with q_ack=1: go to FILL, mem<=0, fill_cnt<=0, q_valid<=0.
- Combinational paths:
  - in_ready = (state==FILL) || q_ack; this allows back-to-back blocks.
  - In HOLD, an accept together with q_ack clears mem and loads the new word: mem <= {in_data, zeros}, fill_cnt=1, len_q re-latched. If len_q==1, stay in HOLD.
- q_ack in FILL: ignored.
- Unused words in short blocks read as zero.
- aclr mid-block: the block is discarded and all state returns to reset values on that edge. aclr overrides accept, flush and ack.
- fill_cnt never exceeds len_q ≤ DEPTH; no wrap-around is possible.

Optional Feature:
SHIFTREG_BUF_LSB_ALIGN_EN
- Defined: q_out is realigned with a registered barrel shift by (DEPTH-fill_cnt)*DATA_W, so the earliest word sits at q_out[DATA_W-1:0].
  - The shift adds one cycle: q_valid rises one cycle later than without the feature.
  - The HOLD exit on q_ack is unchanged.
- Undefined: q_out = mem, with the block MSB-justified.

Decomposition:
- Package shiftreg_buf_pkg:
  - DATA_W default, MAX_K=6144, DEPTH default, CNT_W helper.
  - State enum {FILL, HOLD}.
- One sub-module, shiftreg_buf_align: the barrel realigner, instantiated only under SHIFTREG_BUF_LSB_ALIGN_EN.

Test Plan:
- Full block: blk_len=5, push words 0x01..0x05 with no gaps → q_valid rises the cycle after the 5th accept; q_out top 5 words = 05,04,03,02,01 (MSB→), all lower words 0; fill_cnt=5; in_ready=0.
- Back-pressure: hold q_ack=0 for 10 cycles with in_valid=1 → no accepts, q_out stable. Then q_ack=1 with in_data=0xAA → next block has fill_cnt=1, top word=0xAA, q_valid=0.
- Flush: blk_len=40, push 3 words, then flush=1 → HOLD with fill_cnt=3, q_valid=1. flush with fill_cnt=0 → no state change.
- Length clamp: blk_len=0 and blk_len=DEPTH+5 → each requires exactly DEPTH accepts before q_valid.
- Reset mid-block: aclr after 100 words → next cycle fill_cnt=0, q_out=0, in_ready=1. A 1-word block (blk_len=1) then completes normally.
- With SHIFTREG_BUF_LSB_ALIGN_EN: blk_len=3, words 0x11,0x22,0x33 → q_out[7:0]=0x11, [15:8]=0x22, [23:16]=0x33. q_valid rises 2 cycles after the 3rd accept.
